// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit between the MEM stage and a variable-latency data
// memory. A three-state FSM (IDLE -> ACCESS -> DONE) registers each request and
// holds the memory handshake until mem_ack_i arrives or the wait budget runs out.
// The unit also formats the data: it replicates store data across the lanes,
// generates byte enables, and selects and sign/zero-extends load fields.
//
// Ports
//   clk_i, reset_i            clock (rising edge), asynchronous active-high reset
//   req_i, we_i, adr_i, wd_i  request from the datapath; sampled only in IDLE
//   size_i, unsigned_i        access size (byte/half/word/dword) and load extension
//   busy_o                    FSM is not in IDLE; the core stalls on it
//   done_o, err_o             one-cycle completion pulse and error code
//                             (00 ok, 01 misaligned/illegal, 10 timeout)
//   rdata_o                   formatted load data, held until the next load completes
//   mem_req_o .. mem_wd_o     memory request, driven only while in ACCESS
//   mem_rd_i, mem_ack_i       memory read data and completion
module mem_lsu #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                                   clk_i,
   input  logic                                   reset_i,
   input  logic                                   req_i,
   input  logic                                   we_i,
   input  logic [ADDR_W-1:0]                      adr_i,
   input  logic [DATA_W-1:0]                      wd_i,
   input  logic [1:0]                             size_i,
   input  logic                                   unsigned_i,
   output logic                                   busy_o,
   output logic                                   done_o,
   output logic [DATA_W-1:0]                      rdata_o,
   output logic [1:0]                             err_o,
   output logic                                   mem_req_o,
   output logic                                   mem_we_o,
   output logic [ADDR_W-$clog2(DATA_W/8)-1:0]     mem_adr_o,
   output logic [DATA_W/8-1:0]                    mem_be_o,
   output logic [DATA_W-1:0]                      mem_wd_o,
   input  logic [DATA_W-1:0]                      mem_rd_i,
   input  logic                                   mem_ack_i
);

   localparam int NB = DATA_W / 8;
   localparam int LB = $clog2(NB);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t              state_r, state_nxt_s;
   logic [15:0]         cnt_r, cnt_nxt_s;
   logic [1:0]          err_nxt_s;
   logic                load_rdata_s;
   logic                misalign_s;
   logic                timeout_s;

   logic [LB-1:0]       off_r;
   logic [1:0]          size_r;
   logic                uns_r;
   logic                we_r;

   logic                busy_r, done_r, mem_req_r, mem_we_r;
   logic [1:0]          err_r;
   logic [DATA_W-1:0]   rdata_r, mem_wd_r;
   logic [ADDR_W-LB-1:0] mem_adr_r;
   logic [NB-1:0]       mem_be_r;

   // Number of bytes covered by an access size, clipped to the lane width.
   function automatic int nbytes_f(input logic [1:0] size);
      int n;
      case (size)
         2'b00:   n = 32'sd1;
         2'b01:   n = 32'sd2;
         2'b10:   n = 32'sd4;
         default: n = 32'sd8;
      endcase
      if (n > NB) begin
         n = NB;
      end else begin
         n = n;
      end
      return n;
   endfunction

   // Contiguous byte-enable mask, positioned at the byte offset within the lane.
   function automatic logic [NB-1:0] be_f(input logic [1:0] size, input logic [LB-1:0] off);
      logic [NB-1:0] be;
      int            n;
      n = nbytes_f(size);
      for (int i = 0; i < NB; i++) begin
         be[i] = (i >= int'(off)) && (i < int'(off) + n);
      end
      return be;
   endfunction

   // Lowest size-bytes of the store data replicated across every byte lane.
   function automatic logic [DATA_W-1:0] rep_f(input logic [DATA_W-1:0] wd, input logic [1:0] size);
      logic [DATA_W-1:0] rep;
      int                n;
      n = nbytes_f(size);
      for (int i = 0; i < NB; i++) begin
         rep[8*i +: 8] = wd[8*(i % n) +: 8];
      end
      return rep;
   endfunction

   // Select the field at the byte offset, then zero- or sign-extend it.
   function automatic logic [DATA_W-1:0] fmt_f(input logic [DATA_W-1:0] rd, input logic [LB-1:0] off,
                                               input logic [1:0] size, input logic uns);
      logic [DATA_W-1:0] field;
      logic [DATA_W-1:0] res;
      logic              sign;
      int                n;
      n     = nbytes_f(size);
      field = rd >> {off, 3'b000};
      sign  = field[8*n-1];
      for (int i = 0; i < NB; i++) begin
         if (i < n) begin
            res[8*i +: 8] = field[8*i +: 8];
         end else begin
            res[8*i +: 8] = uns ? 8'h00 : {8{sign}};
         end
      end
      return res;
   endfunction

   // Alignment check on the incoming request; a dword access on 32-bit lanes is illegal.
   always_comb begin
      case (size_i)
         2'b00:   misalign_s = 1'b0;
         2'b01:   misalign_s = adr_i[0];
         2'b10:   misalign_s = |adr_i[1:0];
         2'b11:   misalign_s = (DATA_W == 32) ? 1'b1 : |adr_i[2:0];
         default: misalign_s = 1'b1;
      endcase
   end

   // The counter holds the number of ACCESS cycles already spent without an ack.
   assign timeout_s = (cnt_r == 16'(TIMEOUT - 1));

   // Next-state, counter and completion-code logic.
   always_comb begin
      state_nxt_s  = state_r;
      cnt_nxt_s    = cnt_r;
      err_nxt_s    = 2'b00;
      load_rdata_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            cnt_nxt_s = 16'd0;
            if (req_i) begin
               if (misalign_s) begin
                  state_nxt_s = ST_DONE;
                  err_nxt_s   = 2'b01;
               end else begin
                  state_nxt_s = ST_ACCESS;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            // An ack in the final budget cycle still wins over the timeout.
            if (mem_ack_i) begin
               state_nxt_s  = ST_DONE;
               load_rdata_s = ~we_r;
               cnt_nxt_s    = 16'd0;
            end else if (timeout_s) begin
               state_nxt_s = ST_DONE;
               err_nxt_s   = 2'b10;
               cnt_nxt_s   = 16'd0;
            end else begin
               cnt_nxt_s = cnt_r + 16'd1;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 16'd0;
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 16'd0;
         end
      endcase
   end

   // State and wait-counter registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r <= ST_IDLE;
         cnt_r   <= 16'd0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Capture the request attributes that load formatting needs after IDLE.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         off_r  <= '0;
         size_r <= 2'b00;
         uns_r  <= 1'b0;
         we_r   <= 1'b0;
      end else if ((state_r == ST_IDLE) && req_i) begin
         off_r  <= adr_i[LB-1:0];
         size_r <= size_i;
         uns_r  <= unsigned_i;
         we_r   <= we_i;
      end else begin
         off_r  <= off_r;
         size_r <= size_r;
         uns_r  <= uns_r;
         we_r   <= we_r;
      end
   end

   // Status outputs: busy, done pulse, error code and load data.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 2'b00;
         rdata_r <= '0;
      end else begin
         busy_r <= (state_nxt_s != ST_IDLE);
         done_r <= (state_nxt_s == ST_DONE);
         err_r  <= (state_nxt_s == ST_DONE) ? err_nxt_s : err_r;
         if (load_rdata_s) begin
            rdata_r <= fmt_f(mem_rd_i, off_r, size_r, uns_r);
         end else begin
            rdata_r <= rdata_r;
         end
      end
   end

   // Memory interface: loaded on entry to ACCESS, held through it, zero elsewhere.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         mem_req_r <= 1'b0;
         mem_we_r  <= 1'b0;
         mem_adr_r <= '0;
         mem_be_r  <= '0;
         mem_wd_r  <= '0;
      end else if ((state_r == ST_IDLE) && (state_nxt_s == ST_ACCESS)) begin
         mem_req_r <= 1'b1;
         mem_we_r  <= we_i;
         mem_adr_r <= adr_i[ADDR_W-1:LB];
         mem_be_r  <= be_f(size_i, adr_i[LB-1:0]);
         mem_wd_r  <= rep_f(wd_i, size_i);
      end else if (state_nxt_s == ST_ACCESS) begin
         mem_req_r <= mem_req_r;
         mem_we_r  <= mem_we_r;
         mem_adr_r <= mem_adr_r;
         mem_be_r  <= mem_be_r;
         mem_wd_r  <= mem_wd_r;
      end else begin
         mem_req_r <= 1'b0;
         mem_we_r  <= 1'b0;
         mem_adr_r <= '0;
         mem_be_r  <= '0;
         mem_wd_r  <= '0;
      end
   end

   assign busy_o    = busy_r;
   assign done_o    = done_r;
   assign err_o     = err_r;
   assign rdata_o   = rdata_r;
   assign mem_req_o = mem_req_r;
   assign mem_we_o  = mem_we_r;
   assign mem_adr_o = mem_adr_r;
   assign mem_be_o  = mem_be_r;
   assign mem_wd_o  = mem_wd_r;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: scoreboard bench for mem_lsu. Instance 0 has 32-bit lanes and
// TIMEOUT = 4; instance 1 has 64-bit lanes and TIMEOUT = 8. The stimulus tasks
// push the hand-computed expected memory requests and completions into queues.
// A negedge monitor pops and compares them whenever a DUT raises mem_req_o or
// done_o.
module tb_mem_lsu;

   typedef struct {
      logic [1:0]  err;
      logic [63:0] rdata;
      int          lat;
      int          req_edge;
   } done_exp_t;

   typedef struct {
      logic        we;
      logic [15:0] adr;
      logic [7:0]  be;
      logic [63:0] wd;
      int          len;
   } req_exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic        req_a[2], we_a[2], uns_a[2], ack_a[2];
   logic [1:0]  size_a[2];
   logic [15:0] adr_a[2];
   logic [63:0] wd_a[2], rd_a[2];

   logic        busy0, done0, mreq0, mwe0, busy1, done1, mreq1, mwe1;
   logic [1:0]  err0, err1;
   logic [31:0] rdata0, mwd0;
   logic [63:0] rdata1, mwd1;
   logic [13:0] madr0;
   logic [12:0] madr1;
   logic [3:0]  mbe0;
   logic [7:0]  mbe1;

   done_exp_t dq0[$], dq1[$];
   req_exp_t  rq0[$], rq1[$];
   logic      prev_req[2] = '{1'b0, 1'b0};
   int        req_len[2] = '{0, 0};
   req_exp_t  cur_req[2];

   mem_lsu #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(4)) u32 (
      .clk_i(clk), .reset_i(rst), .req_i(req_a[0]), .we_i(we_a[0]), .adr_i(adr_a[0]),
      .wd_i(wd_a[0][31:0]), .size_i(size_a[0]), .unsigned_i(uns_a[0]), .busy_o(busy0),
      .done_o(done0), .rdata_o(rdata0), .err_o(err0), .mem_req_o(mreq0), .mem_we_o(mwe0),
      .mem_adr_o(madr0), .mem_be_o(mbe0), .mem_wd_o(mwd0), .mem_rd_i(rd_a[0][31:0]),
      .mem_ack_i(ack_a[0]));

   mem_lsu #(.ADDR_W(16), .DATA_W(64), .TIMEOUT(8)) u64 (
      .clk_i(clk), .reset_i(rst), .req_i(req_a[1]), .we_i(we_a[1]), .adr_i(adr_a[1]),
      .wd_i(wd_a[1]), .size_i(size_a[1]), .unsigned_i(uns_a[1]), .busy_o(busy1),
      .done_o(done1), .rdata_o(rdata1), .err_o(err1), .mem_req_o(mreq1), .mem_we_o(mwe1),
      .mem_adr_o(madr1), .mem_be_o(mbe1), .mem_wd_o(mwd1), .mem_rd_i(rd_a[1]),
      .mem_ack_i(ack_a[1]));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: event with no expectation queued (cycle %0d)", name, cyc);
   endtask

   // Scoreboard side: compare memory requests and completions of one DUT.
   task automatic mon(input int d, input logic done, input logic [1:0] err, input logic [63:0] rdata,
                      input logic mreq, input logic mwe, input logic [15:0] madr,
                      input logic [7:0] mbe, input logic [63:0] mwd);
      done_exp_t de;
      int        have;
      if (mreq === 1'b1 && !prev_req[d]) begin
         have = (d == 0) ? rq0.size() : rq1.size();
         if (have == 0) begin
            fail_now($sformatf("dut%0d_unexpected_mem_req", d));
            cur_req[d] = '{we: mwe, adr: madr, be: mbe, wd: mwd, len: 0};
         end else if (d == 0) begin
            cur_req[d] = rq0.pop_front();
         end else begin
            cur_req[d] = rq1.pop_front();
         end
         req_len[d] = 1;
      end else if (mreq === 1'b1) begin
         req_len[d]++;
      end
      if (mreq === 1'b1) begin
         chk($sformatf("dut%0d_mem_we", d), {63'd0, mwe}, {63'd0, cur_req[d].we});
         chk($sformatf("dut%0d_mem_adr", d), {48'd0, madr}, {48'd0, cur_req[d].adr});
         chk($sformatf("dut%0d_mem_be", d), {56'd0, mbe}, {56'd0, cur_req[d].be});
         chk($sformatf("dut%0d_mem_wd", d), mwd, cur_req[d].wd);
      end
      if (mreq !== 1'b1 && prev_req[d] && cur_req[d].len != 0) begin
         chk($sformatf("dut%0d_mem_req_cycles", d), 64'(req_len[d]), 64'(cur_req[d].len));
      end
      prev_req[d] = (mreq === 1'b1);
      if (done === 1'b1) begin
         have = (d == 0) ? dq0.size() : dq1.size();
         if (have == 0) begin
            fail_now($sformatf("dut%0d_unexpected_done", d));
         end else begin
            if (d == 0) de = dq0.pop_front();
            else        de = dq1.pop_front();
            chk($sformatf("dut%0d_err", d), {62'd0, err}, {62'd0, de.err});
            chk($sformatf("dut%0d_rdata", d), rdata, de.rdata);
            chk($sformatf("dut%0d_done_latency", d), 64'(cyc - de.req_edge + 1), 64'(de.lat));
         end
      end
   endtask

   // Monitor: samples both DUTs on the falling edge, away from the active edge.
   always @(negedge clk) begin
      mon(0, done0, err0, {32'd0, rdata0}, mreq0, mwe0, {2'd0, madr0}, {4'd0, mbe0}, {32'd0, mwd0});
      mon(1, done1, err1, rdata1, mreq1, mwe1, {3'd0, madr1}, mbe1, mwd1);
   end

   // Issue one access. waits >= 0: ack after that many wait states; -1: never ack; -2: no memory phase.
   task automatic run(input int d, input logic we, input logic [15:0] adr, input logic [63:0] wd,
                      input logic [1:0] sz, input logic un, input int waits, input logic [63:0] rd,
                      input bit hold, input logic [1:0] e_err, input logic [63:0] e_rdata,
                      input int e_lat, input logic [15:0] e_madr, input logic [7:0] e_be,
                      input logic [63:0] e_wd, input int e_len);
      done_exp_t de;
      req_exp_t  re;
      @(posedge clk); #1;
      req_a[d] = 1'b1; we_a[d] = we; adr_a[d] = adr; wd_a[d] = wd; size_a[d] = sz; uns_a[d] = un;
      de = '{err: e_err, rdata: e_rdata, lat: e_lat, req_edge: cyc + 1};
      re = '{we: we, adr: e_madr, be: e_be, wd: e_wd, len: e_len};
      if (d == 0) dq0.push_back(de); else dq1.push_back(de);
      if (waits != -2) begin
         if (d == 0) rq0.push_back(re); else rq1.push_back(re);
      end
      @(posedge clk); #1;
      if (!hold) req_a[d] = 1'b0;
      if (waits >= 0) begin
         repeat (waits) begin @(posedge clk); #1; end
         ack_a[d] = 1'b1; rd_a[d] = rd;
         @(posedge clk); #1;
         ack_a[d] = 1'b0;
      end else if (waits == -1) begin
         repeat (10) begin @(posedge clk); #1; end
      end
      @(posedge clk); #1;
      req_a[d] = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         req_a[d] = 1'b0; we_a[d] = 1'b0; uns_a[d] = 1'b0; ack_a[d] = 1'b0;
         size_a[d] = 2'b00; adr_a[d] = 16'h0; wd_a[d] = 64'h0; rd_a[d] = 64'h0;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy0", {63'd0, busy0}, 64'd0);
      chk("rst_done0", {63'd0, done0}, 64'd0);
      chk("rst_err0", {62'd0, err0}, 64'd0);
      chk("rst_rdata0", {32'd0, rdata0}, 64'd0);
      chk("rst_mem_req0", {63'd0, mreq0}, 64'd0);
      chk("rst_rdata1", rdata1, 64'd0);
      chk("rst_mem_be1", {56'd0, mbe1}, 64'd0);
      rst = 1'b0;

      // 32-bit lanes: byte store at offset 3, then half store at offset 2
      run(0, 1'b1, 16'h0003, 64'h123456A5, 2'b00, 1'b0, 0, 64'h0, 1'b0,
          2'b00, 64'h0, 2, 16'h0000, 8'h08, 64'hA5A5A5A5, 1);
      run(0, 1'b1, 16'h0002, 64'h7777BEEF, 2'b01, 1'b0, 0, 64'h0, 1'b0,
          2'b00, 64'h0, 2, 16'h0000, 8'h0C, 64'hBEEFBEEF, 1);
      // half loads at 0x0006 with three wait states, signed then unsigned
      run(0, 1'b0, 16'h0006, 64'h0, 2'b01, 1'b0, 3, 64'h80011234, 1'b0,
          2'b00, 64'hFFFF8001, 5, 16'h0001, 8'h0C, 64'h0, 4);
      run(0, 1'b0, 16'h0006, 64'h0, 2'b01, 1'b1, 3, 64'h80011234, 1'b0,
          2'b00, 64'h00008001, 5, 16'h0001, 8'h0C, 64'h0, 4);
      // misaligned word and illegal dword: no memory request, rdata kept
      run(0, 1'b0, 16'h0002, 64'h0, 2'b10, 1'b0, -2, 64'h0, 1'b0,
          2'b01, 64'h00008001, 1, 16'h0, 8'h0, 64'h0, 0);
      run(0, 1'b0, 16'h0000, 64'h0, 2'b11, 1'b0, -2, 64'h0, 1'b0,
          2'b01, 64'h00008001, 1, 16'h0, 8'h0, 64'h0, 0);
      // timeout after four request cycles, then an ack in the fourth cycle wins
      run(0, 1'b0, 16'h0004, 64'h0, 2'b10, 1'b0, -1, 64'h0, 1'b0,
          2'b10, 64'h00008001, 5, 16'h0001, 8'h0F, 64'h0, 4);
      run(0, 1'b0, 16'h0004, 64'h0, 2'b10, 1'b0, 3, 64'hCAFEF00D, 1'b0,
          2'b00, 64'hCAFEF00D, 5, 16'h0001, 8'h0F, 64'h0, 4);

      // reset in the middle of an access: request drops at once, no completion
      @(posedge clk); #1;
      req_a[0] = 1'b1; we_a[0] = 1'b0; adr_a[0] = 16'h0008; size_a[0] = 2'b10; uns_a[0] = 1'b0;
      rq0.push_back('{we: 1'b0, adr: 16'h0002, be: 8'h0F, wd: 64'h0, len: 0});
      @(posedge clk); #1;
      req_a[0] = 1'b0;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("abort_mem_req", {63'd0, mreq0}, 64'd0);
      chk("abort_busy", {63'd0, busy0}, 64'd0);
      chk("abort_done", {63'd0, done0}, 64'd0);
      chk("abort_rdata", {32'd0, rdata0}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      run(0, 1'b0, 16'h0000, 64'h0, 2'b10, 1'b0, 0, 64'h11223344, 1'b0,
          2'b00, 64'h11223344, 2, 16'h0000, 8'h0F, 64'h0, 1);

      // 64-bit lanes
      run(1, 1'b1, 16'h0008, 64'h0123456789ABCDEF, 2'b11, 1'b0, 0, 64'h0, 1'b0,
          2'b00, 64'h0, 2, 16'h0001, 8'hFF, 64'h0123456789ABCDEF, 1);
      run(1, 1'b0, 16'h000F, 64'h0, 2'b00, 1'b0, 0, 64'h8000000000000000, 1'b1,
          2'b00, 64'hFFFFFFFFFFFFFF80, 2, 16'h0001, 8'h80, 64'h0, 1);
      chk("hold_no_restart_busy", {63'd0, busy1}, 64'd0);
      run(1, 1'b0, 16'h0004, 64'h0, 2'b10, 1'b0, 1, 64'h89ABCDEF00000000, 1'b0,
          2'b00, 64'hFFFFFFFF89ABCDEF, 3, 16'h0000, 8'hF0, 64'h0, 2);
      run(1, 1'b0, 16'h0004, 64'h0, 2'b11, 1'b0, -2, 64'h0, 1'b0,
          2'b01, 64'hFFFFFFFF89ABCDEF, 1, 16'h0, 8'h0, 64'h0, 0);

      repeat (4) @(posedge clk);
      chk("done_queue0_drained", 64'(dq0.size()), 64'd0);
      chk("done_queue1_drained", 64'(dq1.size()), 64'd0);
      chk("req_queue0_drained", 64'(rq0.size()), 64'd0);
      chk("req_queue1_drained", 64'(rq1.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Parametrised load/store unit between the datapath and a variable-latency data memory. It replaces the purely combinational byte/half formatting with a registered request/acknowledge FSM. Additions:
- byte-enable writes
- signed and unsigned loads
- 64-bit lanes
- misalignment detection
- bus-timeout detection

Sits in the MEM stage; the core stalls while busy_o is high.

Parameters:
ADDR_W, 16, byte-address width.
DATA_W, 32, data/lane width; legal values 32 or 64.
TIMEOUT, 255, maximum ACCESS cycles waiting for mem_ack_i before a timeout error; legal range 1..65535.

Ports:
clk_i  in  1  clock, rising edge.
reset_i  in  1  reset, asynchronous, active-high.
req_i  in  1  start access; sampled in IDLE only.
we_i  in  1  1 = store, 0 = load.
adr_i  in  ADDR_W  byte address.
wd_i  in  DATA_W  store data, right-aligned.
size_i  in  2  access size: 00 byte, 01 half, 10 word, 11 dword.
unsigned_i  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
busy_o  out  1  FSM not in IDLE.
done_o  out  1  one-cycle completion pulse.
rdata_o  out  DATA_W  formatted load data; held until the next load completes.
err_o  out  2  error code, valid with done_o: 00 ok, 01 misaligned/illegal size, 10 timeout.
mem_req_o  out  1  memory request, held until ack.
mem_we_o  out  1  memory write strobe.
mem_adr_o  out  ADDR_W-LB  lane address, adr[ADDR_W-1:LB], where LB = log2(DATA_W/8).
mem_be_o  out  DATA_W/8  byte enables.
mem_wd_o  out  DATA_W  lane-positioned write data.
mem_rd_i  in  DATA_W  memory read data, valid with mem_ack_i.
mem_ack_i  in  1  memory completion.

Behaviour:
- Reset (asynchronous): state = IDLE; all outputs = 0, including rdata_o and err_o; timeout counter = 0. Asserting reset mid-access drops mem_req_o immediately, and no done_o is produced for the aborted access.
- FSM has three states: IDLE, ACCESS, DONE.
- IDLE, req_i = 1:
  - Register adr, we, wd, size and unsigned.
  - Alignment: byte always aligned; half needs adr[0] = 0; word needs adr[1:0] = 0; dword needs adr[2:0] = 0.
  - size = 11 with DATA_W = 32 is illegal.
  - Misaligned or illegal: go to DONE with err = 01. No memory request is issued.
  - Otherwise: go to ACCESS.
- ACCESS:
  - mem_req_o = 1; mem_we_o = stored we; mem_adr_o, mem_be_o and mem_wd_o stay stable for the whole state.
  - On mem_ack_i: for a load, register the formatted rdata_o. Go to DONE with err = 00.
  - If no ack arrives, increment the counter each cycle. When the counter reaches TIMEOUT, go to DONE with err = 10; rdata_o is unchanged.
  - If ack and timeout occur in the same cycle, the ack wins.
- DONE: done_o = 1 for exactly this cycle; go to IDLE. The counter clears on leaving ACCESS.
- req_i is ignored in ACCESS and DONE.
- mem_ack_i is ignored outside ACCESS.
- Latency:
  - Zero-wait memory (ack in the first ACCESS cycle): done_o is high 2 cycles after the req_i sampling edge.
  - Each wait state adds 1 cycle.
  - Misaligned access: done_o is high 1 cycle after the sampling edge.
- Write formatting:
  - mem_wd_o = the lowest size-bytes of wd replicated across all lanes.
  - mem_be_o = contiguous mask of 1/2/4/8 ones, shifted left by adr[LB-1:0]. Example: DATA_W = 32, half store at offset 2 gives be = 1100.
  - Unused lanes are never written; no sign-fill into other bytes.
- Read formatting: select the size-wide field at byte offset adr[LB-1:0], then zero-extend or sign-extend to DATA_W per unsigned_i.
- busy_o = (state != IDLE), driven from state registers.
- done_o and err_o are registered.
- mem_* outputs are 0 outside ACCESS.

Test Plan:
1. DATA_W = 32, store byte 0xA5 at 0x0003, ack on the first ACCESS cycle -> mem_adr_o = 0x0000, mem_be_o = 1000, mem_wd_o = 0xA5A5A5A5; done_o high 2 cycles after req; err_o = 00.
2. Load half at 0x0006, mem_rd_i = 0x8001_1234, 3 wait states:
   - unsigned_i = 0 -> rdata_o = 0xFFFF8001, done_o high 5 cycles after req.
   - Repeat with unsigned_i = 1 -> rdata_o = 0x00008001.
3. Load word at 0x0002 -> no mem_req_o; done_o high 1 cycle after req; err_o = 01; rdata_o unchanged. size = 11 with DATA_W = 32 -> err_o = 01.
4. TIMEOUT = 4, mem_ack_i held at 0 -> mem_req_o high for exactly 4 cycles; then done_o with err_o = 10. Repeat with the ack arriving in the 4th ACCESS cycle -> err_o = 00.
5. Reset pulsed in the middle of an ACCESS cycle -> mem_req_o = 0 immediately; busy_o = 0; no done_o. A following load at 0x0000 with mem_rd_i = 0x11223344 completes normally with rdata_o = 0x11223344.
6. DATA_W = 64, store dword at 0x0008 -> mem_adr_o = 0x001, mem_be_o = 0xFF. Then load byte at 0x000F from 0x80..., unsigned_i = 0 -> rdata_o = 0xFFFFFFFFFFFFFF80. req_i held high in ACCESS and DONE -> no second access is started.
